// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared types and constants for the pong match controller:
//               game state encoding, field widths, score-bit positions and
//               a saturating score increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int SCORE_W = 8;
    localparam int VEL_W   = 8;
    localparam int TIMER_W = 16;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'd255;
    localparam int SCORE_LEFT_BIT  = 1;
    localparam int SCORE_RIGHT_BIT = 0;

    typedef enum logic [1:0] {
        GS_IDLE      = 2'd0,
        GS_SERVE     = 2'd1,
        GS_PLAY      = 2'd2,
        GS_GAME_OVER = 2'd3
    } game_state_t;

    // Scores stick at SCORE_MAX instead of wrapping to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serve_timer.sv
`default_nettype none
// ============================================================================
// Module      : serve_timer
// Description : Frame-tick down-counter that paces the SERVE phase.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   load     : reload the count with DELAY (wins over tick)
//   tick     : one frame elapsed; decrements a non-zero count
//   done     : combinational, high on the tick that consumes the last frame
// Revision    : 1.0 - initial release
// ============================================================================
module serve_timer
    import pong_pkg::*;
#(
    parameter int unsigned DELAY = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(DELAY);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A tick that lands on a load cycle is swallowed by the reload, so the
    // caller sees exactly DELAY ticks after entering SERVE.
    assign done = tick && !load && (count_q == TIMER_W'(1));

endmodule
`default_nettype wire

// File: rtl/pong_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : pong_game_controller
// Description : Match-level controller for the pong physics core. Tracks
//               scores, runs IDLE/SERVE/PLAY/GAME_OVER and issues re-serve
//               position/velocity with a one-cycle ball_reset pulse.
//   Inputs  : clk, rst (sync, active-high), frame_tick, start,
//             dimensions {width,height}, player_did_score {left,right}
//   Outputs : score {left,right}, game_state, play_en, ball_reset,
//             ball_position_init {w/2,h/2}, ball_velocity_init {vx,vy},
//             winner {left,right}
//   Build option : define PONG_WIN_BY_TWO_EN to require a two-point lead.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int unsigned       WIN_SCORE   = 11,
    parameter int unsigned       SERVE_DELAY = 60,
    parameter logic signed [7:0] SERVE_VX    = 8'sd2,
    parameter logic signed [7:0] SERVE_VY    = 8'sd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic [31:0] dimensions,
    input  logic [1:0]  player_did_score,
    output logic [15:0] score,
    output logic [1:0]  game_state,
    output logic        play_en,
    output logic        ball_reset,
    output logic [31:0] ball_position_init,
    output logic [15:0] ball_velocity_init,
    output logic [1:0]  winner
);

`ifdef PONG_WIN_BY_TWO_EN
    localparam bit WIN_BY_TWO = 1'b1;
`else
    localparam bit WIN_BY_TWO = 1'b0;
`endif

    game_state_t        state_q,      state_d;
    logic [SCORE_W-1:0] score_l_q,    score_l_d;
    logic [SCORE_W-1:0] score_r_q,    score_r_d;
    logic [1:0]         winner_q,     winner_d;
    logic               ball_reset_q, ball_reset_d;
    logic               play_en_q,    play_en_d;
    logic [31:0]        pos_q,        pos_d;
    logic [15:0]        vel_q,        vel_d;
    logic               vy_neg_q,     vy_neg_d;

    logic serve_now;     // entering SERVE on this edge
    logic serve_first;   // first serve of a match: vy restarts positive
    logic serve_vx_neg;  // serve toward the left player
    logic timer_done;
    logic left_pt;
    logic right_pt;

    // Win check on the scorer's post-point total. With win-by-two, a point
    // scored from 255-255 ends the game since neither side can pull ahead.
    function automatic logic is_win(input logic [SCORE_W-1:0] old_s,
                                    input logic [SCORE_W-1:0] new_s,
                                    input logic [SCORE_W-1:0] other);
        logic reached;
        logic lead2;
        logic both_max;
        reached  = 32'(new_s) >= WIN_SCORE;
        lead2    = {1'b0, new_s} >= ({1'b0, other} + 9'd2);
        both_max = (old_s == SCORE_MAX) && (other == SCORE_MAX);
        return WIN_BY_TWO ? ((reached && lead2) || both_max) : reached;
    endfunction

    assign left_pt  = player_did_score[SCORE_LEFT_BIT]  & ~player_did_score[SCORE_RIGHT_BIT];
    assign right_pt = player_did_score[SCORE_RIGHT_BIT] & ~player_did_score[SCORE_LEFT_BIT];

    serve_timer #(
        .DELAY (SERVE_DELAY)
    ) u_serve_timer (
        .clk  (clk),
        .rst  (rst),
        .load (serve_now),
        .tick (frame_tick),
        .done (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        score_l_d    = score_l_q;
        score_r_d    = score_r_q;
        winner_d     = winner_q;
        pos_d        = pos_q;
        vel_d        = vel_q;
        vy_neg_d     = vy_neg_q;
        serve_now    = 1'b0;
        serve_first  = 1'b0;
        serve_vx_neg = 1'b0;

        unique case (state_q)
            GS_IDLE, GS_GAME_OVER: begin
                if (start) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    winner_d    = 2'b00;
                    state_d     = GS_SERVE;
                    serve_now   = 1'b1;
                    serve_first = 1'b1;
                end
            end
            GS_SERVE: begin
                if (timer_done) begin
                    state_d = GS_PLAY;
                end
            end
            GS_PLAY: begin
                if (left_pt) begin
                    score_l_d = sat_inc(score_l_q);
                    if (is_win(score_l_q, score_l_d, score_r_q)) begin
                        state_d  = GS_GAME_OVER;
                        winner_d = 2'b10;
                    end else begin
                        state_d   = GS_SERVE;
                        serve_now = 1'b1;
                    end
                end else if (right_pt) begin
                    score_r_d = sat_inc(score_r_q);
                    if (is_win(score_r_q, score_r_d, score_l_q)) begin
                        state_d  = GS_GAME_OVER;
                        winner_d = 2'b01;
                    end else begin
                        state_d      = GS_SERVE;
                        serve_now    = 1'b1;
                        serve_vx_neg = 1'b1;
                    end
                end
            end
            default: state_d = GS_IDLE;
        endcase

        // Serve parameters are latched alongside the ball_reset pulse and
        // held until the next serve.
        if (serve_now) begin
            vy_neg_d = serve_first ? 1'b0 : ~vy_neg_q;
            pos_d    = {dimensions[31:16] >> 1, dimensions[15:0] >> 1};
            vel_d    = {serve_vx_neg ? -SERVE_VX : SERVE_VX,
                        vy_neg_d     ? -SERVE_VY : SERVE_VY};
        end

        ball_reset_d = serve_now;
        play_en_d    = (state_d == GS_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= GS_IDLE;
            score_l_q    <= '0;
            score_r_q    <= '0;
            winner_q     <= 2'b00;
            ball_reset_q <= 1'b0;
            play_en_q    <= 1'b0;
            pos_q        <= '0;
            vel_q        <= '0;
            vy_neg_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            winner_q     <= winner_d;
            ball_reset_q <= ball_reset_d;
            play_en_q    <= play_en_d;
            pos_q        <= pos_d;
            vel_q        <= vel_d;
            vy_neg_q     <= vy_neg_d;
        end
    end

    assign score              = {score_l_q, score_r_q};
    assign game_state         = state_q;
    assign play_en            = play_en_q;
    assign ball_reset         = ball_reset_q;
    assign ball_position_init = pos_q;
    assign ball_velocity_init = vel_q;
    assign winner             = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_game_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pong_game_controller
// Description : Self-checking bench for pong_game_controller. A match-level
//               reference model tracks the expected outputs; directed
//               sequences pin key literal values, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_game_controller;

    localparam int WIN       = 3;
    localparam int DELAY     = 3;
    localparam int VX        = 2;
    localparam int VY        = 1;
    localparam logic [31:0] DIM0 = 32'h0280_01E0;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic [31:0] dimensions;
    logic [1:0]  player_did_score;
    logic [15:0] score;
    logic [1:0]  game_state;
    logic        play_en;
    logic        ball_reset;
    logic [31:0] ball_position_init;
    logic [15:0] ball_velocity_init;
    logic [1:0]  winner;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: match-level view of the game.
    int          m_state = 0;  // 0 idle, 1 serve, 2 play, 3 game over
    int          m_l = 0, m_r = 0, m_win = 0;
    int          m_vx = 0, m_vy = 0, m_ticks = 0;
    bit          m_br = 0;
    logic [31:0] m_pos = '0;

    always #5 clk = ~clk;

    pong_game_controller #(
        .WIN_SCORE   (WIN),
        .SERVE_DELAY (DELAY),
        .SERVE_VX    (8'sd2),
        .SERVE_VY    (8'sd1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_tick         (frame_tick),
        .start              (start),
        .dimensions         (dimensions),
        .player_did_score   (player_did_score),
        .score              (score),
        .game_state         (game_state),
        .play_en            (play_en),
        .ball_reset         (ball_reset),
        .ball_position_init (ball_position_init),
        .ball_velocity_init (ball_velocity_init),
        .winner             (winner)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic serve(input int dir, input bit first);
        m_state = 1;
        m_ticks = 0;
        m_vy    = first ? VY : -m_vy;
        m_vx    = dir * VX;
        m_pos   = {dimensions[31:16] / 16'd2, dimensions[15:0] / 16'd2};
        m_br    = 1;
    endtask

    task automatic point(input bit left);
        int s, o, ns;
        bit won;
        s  = left ? m_l : m_r;
        o  = left ? m_r : m_l;
        ns = (s < 255) ? s + 1 : 255;
`ifdef PONG_WIN_BY_TWO_EN
        won = (s == 255 && o == 255) || (ns >= WIN && ns - o >= 2);
`else
        won = ns >= WIN;
`endif
        if (left) m_l = ns; else m_r = ns;
        if (won) begin
            m_state = 3;
            m_win   = left ? 2 : 1;
        end else begin
            serve(left ? 1 : -1, 0);
        end
    endtask

    task automatic model_step();
        m_br = 0;
        if (rst) begin
            m_state = 0; m_l = 0; m_r = 0; m_win = 0;
            m_vx = 0; m_vy = 0; m_ticks = 0; m_pos = '0;
        end else begin
            case (m_state)
                0, 3: if (start) begin
                    m_l = 0; m_r = 0; m_win = 0;
                    serve(1, 1);
                end
                1: if (frame_tick) begin
                    m_ticks++;
                    if (m_ticks == DELAY) m_state = 2;
                end
                2: if (player_did_score == 2'b10) point(1);
                   else if (player_did_score == 2'b01) point(0);
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check("score",      {16'h0, score},      {16'h0, 8'(m_l), 8'(m_r)});
        check("game_state", {30'h0, game_state}, 32'(m_state));
        check("play_en",    {31'h0, play_en},    {31'h0, m_state == 2});
        check("ball_reset", {31'h0, ball_reset}, {31'h0, m_br});
        check("ball_pos",   ball_position_init,  m_pos);
        check("ball_vel",   {16'h0, ball_velocity_init}, {16'h0, 8'(m_vx), 8'(m_vy)});
        check("winner",     {30'h0, winner},     32'(m_win));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        compare_all();
    end

    // Drive one cycle of inputs and return at the following negedge.
    task automatic step(input logic r, input logic s, input logic t, input logic [1:0] p);
        rst = r; start = s; frame_tick = t; player_did_score = p;
        @(negedge clk);
    endtask

    task automatic to_play();
        for (int i = 0; i < DELAY; i++) step(0, 0, 1, 2'b00);
    endtask

    initial begin
        dimensions = DIM0;
        step(1, 0, 0, 2'b00);
        check("rst_state", {30'h0, game_state}, 32'd0);
        check("rst_score", {16'h0, score}, 32'd0);
        check("rst_vel",   {16'h0, ball_velocity_init}, 32'd0);

        // Match start: serve with +vx, +vy from the playfield centre.
        step(0, 1, 0, 2'b00);
        check("start_br",  {31'h0, ball_reset}, 32'd1);
        check("start_pos", ball_position_init, 32'h0140_00F0);
        check("start_vel", {16'h0, ball_velocity_init}, 32'h0201);
        step(0, 0, 0, 2'b00);
        check("br_pulse",  {31'h0, ball_reset}, 32'd0);
        step(0, 0, 0, 2'b10);
        check("serve_ign", {16'h0, score}, 32'd0);
        step(0, 0, 1, 2'b00);
        step(0, 0, 1, 2'b00);
        check("serve_hold", {30'h0, game_state}, 32'd1);
        step(0, 0, 1, 2'b00);
        check("to_play",   {30'h0, game_state}, 32'd2);
        check("play_en",   {31'h0, play_en}, 32'd1);

        step(0, 0, 0, 2'b11);
        check("illegal11", {14'h0, game_state, score}, 32'h0002_0000);
        step(0, 0, 0, 2'b01);
        check("right_pt",  {16'h0, score}, 32'h0001);
        check("right_vel", {16'h0, ball_velocity_init}, 32'hFEFF);
        check("right_st",  {30'h0, game_state}, 32'd1);

        to_play(); step(0, 0, 0, 2'b10);
        check("left_vel",  {16'h0, ball_velocity_init}, 32'h0201);
        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b10);
        check("go_state",  {30'h0, game_state}, 32'd3);
        check("go_winner", {30'h0, winner}, 32'd2);
        check("go_score",  {16'h0, score}, 32'h0301);
        check("go_play_en", {31'h0, play_en}, 32'd0);
        step(0, 0, 0, 2'b10);
        check("go_ign",    {16'h0, score}, 32'h0301);

        step(0, 1, 0, 2'b00);
        check("restart",   {14'h0, winner, score}, 32'd0);
        check("restart_vel", {16'h0, ball_velocity_init}, 32'h0201);

        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b01);
        check("pre_rst",   {16'h0, score}, 32'h0201);
        step(0, 0, 1, 2'b00);
        step(1, 0, 0, 2'b01);
        check("mid_rst",   {ball_velocity_init, score}, 32'd0);
        check("mid_rst_pos", ball_position_init, 32'd0);
        check("mid_rst_st", {28'h0, game_state, winner}, 32'd0);
        step(0, 1, 0, 2'b00);
        check("fresh",     {30'h0, game_state}, 32'd1);

`ifdef PONG_WIN_BY_TWO_EN
        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b01);
        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b01);
        to_play(); step(0, 0, 0, 2'b10);
        to_play(); step(0, 0, 0, 2'b01);
        check("deuce",     {16'h0, score}, 32'h0303);
        to_play(); step(0, 0, 0, 2'b10);
        check("adv_score", {16'h0, score}, 32'h0403);
        check("adv_state", {30'h0, game_state}, 32'd1);
        to_play(); step(0, 0, 0, 2'b10);
        check("wb2_state", {30'h0, game_state}, 32'd3);
        check("wb2_score", {16'h0, score}, 32'h0503);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) dimensions = $urandom;
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 9) < 7) ? 2'b00 : 2'($urandom_range(0, 3)));
        end

        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
